// File: rtl/core_wb_arbiter_bridge_pkg.sv
// Shared types and helpers for the core-port to Wishbone bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package core_bus_pkg;

  // Bridge sequencer: grant in IDLE, run the Wishbone cycle in BUS, pulse the response in RESP.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } bridge_state_e;

  localparam int ARB_FIXED = 0;  // lowest asserted index wins
  localparam int ARB_RR    = 1;  // rotating priority starting at the pointer

  // Number of byte lanes on a data bus.
  function automatic int sel_width(input int data_width);
    return data_width / 8;
  endfunction

  // Index width that stays at least one bit when there is a single port.
  function automatic int idx_width(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage

// File: rtl/core_wb_arbiter_bridge_rr_arbiter.sv
// Request arbiter: fixed priority or round robin over NUM_PORTS requesters.
// Latency: combinational grant; pointer advances on the clock edge of a taken grant.
// Backpressure: grants only while i_grant_en is high; otherwise the pointer holds.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset (pointer returns to 0)
//   i_req        : per-port request vector
//   i_grant_en   : the owner is ready to accept a grant this cycle
//   o_grant_oh   : one-hot winner (zero when nothing requests)
//   o_grant_idx  : binary index of the winner
module rr_arbiter
  import core_bus_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ARB_MODE  = ARB_FIXED
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            i_req,
  input  logic                            i_grant_en,
  output logic [NUM_PORTS-1:0]            o_grant_oh,
  output logic [idx_width(NUM_PORTS)-1:0] o_grant_idx
);

  localparam int IDX_W = idx_width(NUM_PORTS);

  logic [IDX_W-1:0] r_ptr;
  logic             w_found;
  int               w_cand;

  // Scan from the start position; the first asserted request wins.
  // In fixed mode the start is always 0, which degenerates to lowest-index priority.
  always_comb begin
    o_grant_oh  = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_cand      = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (ARB_MODE == ARB_RR) begin
        w_cand = (int'(r_ptr) + k) % NUM_PORTS;
      end else begin
        w_cand = k;
      end
      if (!w_found && i_req[w_cand]) begin
        w_found             = 1'b1;
        o_grant_oh[w_cand]  = 1'b1;
        o_grant_idx         = IDX_W'(w_cand);
      end
    end
  end

  // Pointer moves just past the winner so that port gets lowest priority next time.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if ((ARB_MODE == ARB_RR) && i_grant_en && w_found) begin
      if (o_grant_idx == IDX_W'(NUM_PORTS - 1)) begin
        r_ptr <= '0;
      end else begin
        r_ptr <= o_grant_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/core_wb_arbiter_bridge.sv
// Bridge from N native core memory ports onto one Wishbone classic master with bus timeout.
// Latency: request sampled at T -> ready/cyc at T+1 -> zero-wait ack at T+1 -> rsp_valid at T+3.
// Backpressure: one transaction in flight; other ports hold req_valid_i until their ready pulse.
//
// Ports:
//   clk, rst                  : core clock, synchronous active-high reset
//   req_*_i / req_ready_o     : packed per-port request channel, ready is a one-cycle grant pulse
//   rsp_valid_o/rdata/err     : one-hot response pulse with shared data and error flag
//   wb_*                      : Wishbone classic master (cyc/stb/we/addr/data/sel, ack/err/data in)
module core_wb_arbiter_bridge
  import core_bus_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ARB_MODE       = ARB_FIXED,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_PORTS-1:0]                      req_valid_i,
  output logic [NUM_PORTS-1:0]                      req_ready_o,
  input  logic [NUM_PORTS-1:0]                      req_we_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]           req_addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]           req_wdata_i,
  input  logic [NUM_PORTS*sel_width(DATA_WIDTH)-1:0] req_be_i,
  output logic [NUM_PORTS-1:0]                      rsp_valid_o,
  output logic [DATA_WIDTH-1:0]                     rsp_rdata_o,
  output logic                                      rsp_err_o,
  output logic                                      wb_cyc_o,
  output logic                                      wb_stb_o,
  output logic                                      wb_we_o,
  output logic [ADDR_WIDTH-1:0]                     wb_addr_o,
  output logic [DATA_WIDTH-1:0]                     wb_data_o,
  output logic [sel_width(DATA_WIDTH)-1:0]          wb_sel_o,
  input  logic [DATA_WIDTH-1:0]                     wb_data_i,
  input  logic                                      wb_ack_i,
  input  logic                                      wb_err_i
);

  localparam int SEL_W = sel_width(DATA_WIDTH);
  localparam int IDX_W = idx_width(NUM_PORTS);
  // Zero timeout keeps a 1-bit counter that is never compared.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  bridge_state_e          r_state;
  logic [NUM_PORTS-1:0]   r_owner;
  logic [NUM_PORTS-1:0]   r_req_ready;
  logic [NUM_PORTS-1:0]   r_rsp_valid;
  logic [DATA_WIDTH-1:0]  r_rsp_rdata;
  logic                   r_rsp_err;
  logic                   r_wb_cyc;
  logic                   r_wb_stb;
  logic                   r_wb_we;
  logic [ADDR_WIDTH-1:0]  r_wb_addr;
  logic [DATA_WIDTH-1:0]  r_wb_data;
  logic [SEL_W-1:0]       r_wb_sel;
  logic [CNT_W-1:0]       r_cnt;

  logic                   w_grant_en;
  logic [NUM_PORTS-1:0]   w_grant_oh;
  logic [IDX_W-1:0]       w_grant_idx;
  logic                   w_timeout;
  logic                   w_sel_we;
  logic [ADDR_WIDTH-1:0]  w_sel_addr;
  logic [DATA_WIDTH-1:0]  w_sel_wdata;
  logic [SEL_W-1:0]       w_sel_be;

  assign w_grant_en = (r_state == IDLE);

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .ARB_MODE  (ARB_MODE)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .i_req       (req_valid_i),
    .i_grant_en  (w_grant_en),
    .o_grant_oh  (w_grant_oh),
    .o_grant_idx (w_grant_idx)
  );

  // Winner's request fields, selected by index from the packed buses.
  assign w_sel_we    = req_we_i[w_grant_idx];
  assign w_sel_addr  = req_addr_i[w_grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_sel_wdata = req_wdata_i[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
  assign w_sel_be    = req_be_i[w_grant_idx*SEL_W +: SEL_W];

  assign w_timeout = (TIMEOUT_CYCLES > 0) && (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_owner     <= '0;
      r_req_ready <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_wb_cyc    <= 1'b0;
      r_wb_stb    <= 1'b0;
      r_wb_we     <= 1'b0;
      r_wb_addr   <= '0;
      r_wb_data   <= '0;
      r_wb_sel    <= '0;
      r_cnt       <= '0;
    end else begin
      // Ready and response are single-cycle pulses.
      r_req_ready <= '0;
      r_rsp_valid <= '0;
      case (r_state)
        IDLE: begin
          if (|req_valid_i) begin
            r_req_ready <= w_grant_oh;
            r_owner     <= w_grant_oh;
            r_wb_we     <= w_sel_we;
            r_wb_addr   <= w_sel_addr;
            r_wb_data   <= w_sel_wdata;
            r_wb_sel    <= w_sel_be;
            r_wb_cyc    <= 1'b1;
            r_wb_stb    <= 1'b1;
            r_cnt       <= '0;
            r_state     <= BUS;
          end
        end
        BUS: begin
          // Slave error beats a simultaneous ack; a real ack beats a timeout in the same cycle.
          if (wb_err_i) begin
            r_wb_cyc    <= 1'b0;
            r_wb_stb    <= 1'b0;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
            r_state     <= RESP;
          end else if (wb_ack_i) begin
            r_wb_cyc    <= 1'b0;
            r_wb_stb    <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= r_wb_we ? '0 : wb_data_i;
            r_state     <= RESP;
          end else if (w_timeout) begin
            r_wb_cyc    <= 1'b0;
            r_wb_stb    <= 1'b0;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
            r_state     <= RESP;
          end else if (TIMEOUT_CYCLES > 0) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          r_rsp_valid <= r_owner;
          r_cnt       <= '0;
          r_state     <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign req_ready_o = r_req_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_err_o   = r_rsp_err;
  assign wb_cyc_o    = r_wb_cyc;
  assign wb_stb_o    = r_wb_stb;
  assign wb_we_o     = r_wb_we;
  assign wb_addr_o   = r_wb_addr;
  assign wb_data_o   = r_wb_data;
  assign wb_sel_o    = r_wb_sel;

endmodule

// File: tb/tb_core_wb_arbiter_bridge.sv
// Directed bench for core_wb_arbiter_bridge: instance a is fixed priority, instance b round robin.
// Both share every input, so they run in lockstep timing and differ only in who is granted.
// Expected values are hand-computed constants.
module tb_core_wb_arbiter_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_we    = '0;
  logic [63:0] req_addr  = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_be    = '0;
  logic [31:0] wb_data_in = 32'hA5A5A5A5;
  logic        wb_ack = 1'b0;
  logic        wb_err = 1'b0;

  logic [1:0]  a_req_ready, a_rsp_valid, b_req_ready, b_rsp_valid;
  logic [31:0] a_rsp_rdata, b_rsp_rdata, a_wb_addr, b_wb_addr, a_wb_data, b_wb_data;
  logic        a_rsp_err, b_rsp_err, a_wb_cyc, b_wb_cyc, a_wb_stb, b_wb_stb, a_wb_we, b_wb_we;
  logic [3:0]  a_wb_sel, b_wb_sel;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  core_wb_arbiter_bridge #(
    .NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(0), .TIMEOUT_CYCLES(16)
  ) dut_a (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(a_req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(a_rsp_valid), .rsp_rdata_o(a_rsp_rdata), .rsp_err_o(a_rsp_err),
    .wb_cyc_o(a_wb_cyc), .wb_stb_o(a_wb_stb), .wb_we_o(a_wb_we), .wb_addr_o(a_wb_addr),
    .wb_data_o(a_wb_data), .wb_sel_o(a_wb_sel),
    .wb_data_i(wb_data_in), .wb_ack_i(wb_ack), .wb_err_i(wb_err)
  );

  core_wb_arbiter_bridge #(
    .NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(1), .TIMEOUT_CYCLES(16)
  ) dut_b (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(b_req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(b_rsp_valid), .rsp_rdata_o(b_rsp_rdata), .rsp_err_o(b_rsp_err),
    .wb_cyc_o(b_wb_cyc), .wb_stb_o(b_wb_stb), .wb_we_o(b_wb_we), .wb_addr_o(b_wb_addr),
    .wb_data_o(b_wb_data), .wb_sel_o(b_wb_sel),
    .wb_data_i(wb_data_in), .wb_ack_i(wb_ack), .wb_err_i(wb_err)
  );

  task automatic chk_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req_valid = '0;
    wb_ack = 1'b0;
    wb_err = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  // One transaction on 'port'. The slave answers after wait_n extra cycles of cyc
  // (ack/err may both be zero to let the timeout fire). Returns latency from
  // request cycle to rsp_valid, number of cyc-high cycles, and the response.
  task automatic run_txn(input int port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, input int wait_n,
                         input logic ack, input logic err, input logic [31:0] rdata,
                         output int lat, output int ncyc, output logic [1:0] vld,
                         output logic [31:0] got_rdata, output logic got_err);
    logic [1:0] exp_rdy;
    logic       found;
    exp_rdy = 2'b01 << port;
    found   = 1'b0;
    ncyc    = 0;
    vld     = '0;
    got_rdata = '0;
    got_err = 1'b0;
    req_we[port]              = we;
    req_addr[port*32 +: 32]   = addr;
    req_wdata[port*32 +: 32]  = wdata;
    req_be[port*4 +: 4]       = be;
    req_valid                 = exp_rdy;
    tick;
    lat = 1;
    chk_eq("req_ready", a_req_ready, exp_rdy);
    chk_eq("wb_cyc_stb", {a_wb_cyc, a_wb_stb}, 2'b11);
    chk_eq("wb_fields", {a_wb_we, a_wb_addr, a_wb_data, a_wb_sel}, {we, addr, wdata, be});
    req_valid = '0;
    for (int k = 0; k < 64; k++) begin
      if (|a_rsp_valid) begin
        found = 1'b1;
        break;
      end
      if (a_wb_cyc) ncyc++;
      if (a_wb_cyc && (ncyc == wait_n + 1) && (ack || err)) begin
        wb_ack = ack;
        wb_err = err;
        wb_data_in = rdata;
      end
      tick;
      lat++;
      wb_ack = 1'b0;
      wb_err = 1'b0;
      wb_data_in = 32'hA5A5A5A5;
    end
    chk_eq("rsp_arrived", found, 1'b1);
    vld = a_rsp_valid;
    got_rdata = a_rsp_rdata;
    got_err = a_rsp_err;
    tick;
    chk_eq("rsp_one_cycle", a_rsp_valid, 2'b00);
  endtask

  int          lat, ncyc, na, nb;
  logic [1:0]  vld, seen;
  logic [31:0] rdata;
  logic        err;
  logic [1:0]  ga [4];
  logic [1:0]  gb [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    tick;
    tick;
    chk_eq("reset_a", {a_req_ready, a_rsp_valid, a_wb_cyc, a_wb_stb, a_wb_we, a_rsp_err,
                       a_wb_addr, a_wb_data, a_wb_sel, a_rsp_rdata}, '0);
    chk_eq("reset_b", {b_req_ready, b_rsp_valid, b_wb_cyc, b_wb_stb, b_wb_we, b_rsp_err,
                       b_wb_addr, b_wb_data, b_wb_sel, b_rsp_rdata}, '0);
    rst = 1'b0;
    tick;

    // Port 1 read, zero-wait ack
    run_txn(1, 1'b0, 32'h100, 32'h0, 4'hF, 0, 1'b1, 1'b0, 32'hDEADBEEF, lat, ncyc, vld, rdata, err);
    chk_eq("rd_vld", vld, 2'b10);
    chk_eq("rd_data", rdata, 32'hDEADBEEF);
    chk_eq("rd_err", err, 1'b0);
    chk_eq("rd_latency", lat, 3);

    // Port 0 write: read data bus is junk but writes return zero
    run_txn(0, 1'b1, 32'h200, 32'h12345678, 4'b0011, 0, 1'b1, 1'b0, 32'hCAFEF00D,
            lat, ncyc, vld, rdata, err);
    chk_eq("wr_vld", vld, 2'b01);
    chk_eq("wr_err", err, 1'b0);
    chk_eq("wr_rdata_zero", rdata, 32'h0);

    // Two wait states stretch the latency by two
    run_txn(0, 1'b0, 32'h300, 32'h0, 4'hF, 2, 1'b1, 1'b0, 32'h0BADF00D, lat, ncyc, vld, rdata, err);
    chk_eq("wait_latency", lat, 5);
    chk_eq("wait_cyc_cycles", ncyc, 3);
    chk_eq("wait_data", rdata, 32'h0BADF00D);

    // Arbitration with both ports requesting continuously
    do_reset;
    req_addr  = {32'h1100, 32'h1000};
    req_we    = 2'b00;
    req_valid = 2'b11;
    na = 0;
    nb = 0;
    for (int c = 0; c < 20; c++) begin
      if (a_req_ready != 2'b00) begin
        if (na < 4) ga[na] = a_req_ready;
        na++;
      end
      if (b_req_ready != 2'b00) begin
        if (nb < 4) gb[nb] = b_req_ready;
        nb++;
      end
      if (na >= 4) req_valid = 2'b00;
      wb_ack = a_wb_cyc;
      wb_data_in = 32'h0;
      tick;
    end
    wb_ack = 1'b0;
    wb_data_in = 32'hA5A5A5A5;
    chk_eq("arb_count_a", na, 4);
    chk_eq("arb_count_b", nb, 4);
    for (int k = 0; k < 4; k++) begin
      chk_eq("arb_fixed", ga[k], 2'b01);
      chk_eq("arb_rr", gb[k], (k % 2 == 0) ? 2'b01 : 2'b10);
    end

    // Slave never answers: timeout after 16 cycles of cyc
    run_txn(1, 1'b0, 32'h400, 32'h0, 4'hF, 0, 1'b0, 1'b0, 32'h0, lat, ncyc, vld, rdata, err);
    chk_eq("to_cyc_cycles", ncyc, 16);
    chk_eq("to_err", err, 1'b1);
    chk_eq("to_vld", vld, 2'b10);
    chk_eq("to_latency", lat, 18);

    // Next request after a timeout behaves normally
    run_txn(1, 1'b0, 32'h404, 32'h0, 4'hF, 0, 1'b1, 1'b0, 32'h55AA55AA, lat, ncyc, vld, rdata, err);
    chk_eq("post_to_data", rdata, 32'h55AA55AA);
    chk_eq("post_to_err", err, 1'b0);

    // Ack and err together: err wins
    run_txn(0, 1'b0, 32'h500, 32'h0, 4'hF, 1, 1'b1, 1'b1, 32'h11111111, lat, ncyc, vld, rdata, err);
    chk_eq("ack_err_err", err, 1'b1);
    chk_eq("ack_err_vld", vld, 2'b01);

    // Stray ack/err while idle produce nothing
    wb_ack = 1'b1;
    wb_err = 1'b1;
    tick;
    wb_ack = 1'b0;
    wb_err = 1'b0;
    seen = 2'b00;
    for (int k = 0; k < 4; k++) begin
      seen = seen | a_rsp_valid | {a_wb_cyc, a_wb_cyc};
      tick;
    end
    chk_eq("stray_ack", seen, 2'b00);

    // Reset while cyc is high. Leave b's pointer at 1 first.
    run_txn(0, 1'b0, 32'h600, 32'h0, 4'hF, 0, 1'b1, 1'b0, 32'h0, lat, ncyc, vld, rdata, err);
    req_addr[31:0] = 32'h700;
    req_valid = 2'b01;
    tick;
    chk_eq("mid_cyc_up", {a_wb_cyc, b_wb_cyc}, 2'b11);
    req_valid = 2'b00;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk_eq("mid_rst_cyc", {a_wb_cyc, a_wb_stb, b_wb_cyc, b_wb_stb}, 4'b0000);
    seen = 2'b00;
    for (int k = 0; k < 4; k++) begin
      seen = seen | a_rsp_valid | b_rsp_valid;
      tick;
    end
    chk_eq("mid_rst_no_rsp", seen, 2'b00);
    req_valid = 2'b11;
    tick;
    chk_eq("rr_ptr_reset", b_req_ready, 2'b01);
    chk_eq("fixed_after_rst", a_req_ready, 2'b01);
    req_valid = 2'b00;
    for (int k = 0; k < 5; k++) begin
      wb_ack = a_wb_cyc;
      tick;
    end
    wb_ack = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/core_wb_arbiter_bridge.md
Name: core_wb_arbiter_bridge

Overview:
Generalised bridge between N native core memory ports and one Wishbone classic master bus toward the Controller. Replaces the hard-wired cyc/stb/we glue used per core today. Adds:
- request/response handshaking
- byte selects
- arbitration between ports (e.g. instruction + data on one bus when the second memory is disabled)
- a bus-timeout that converts a hung slave into an error response to the core.

Parameters:
NUM_PORTS, 2, number of native request ports (1..8); port 0 is conventionally instruction fetch
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width; multiple of 8
ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round robin
TIMEOUT_CYCLES, 1024, cycles with cyc high and no ack/err before forced error; 0 disables timeout

Ports:
clk  in  1  core clock (clk_core domain)
rst  in  1  synchronous active-high reset
req_valid_i  in  NUM_PORTS  per-port request valid
req_ready_o  out  NUM_PORTS  per-port request accepted (one-hot or zero)
req_we_i  in  NUM_PORTS  1 = write
req_addr_i  in  NUM_PORTS*ADDR_WIDTH  packed addresses, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata_i  in  NUM_PORTS*DATA_WIDTH  packed write data
req_be_i  in  NUM_PORTS*(DATA_WIDTH/8)  packed byte enables
rsp_valid_o  out  NUM_PORTS  one-cycle response pulse, one-hot
rsp_rdata_o  out  DATA_WIDTH  read data, shared, qualified by rsp_valid_o
rsp_err_o  out  1  error flag, qualified by rsp_valid_o
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_we_o  out  1  Wishbone write enable
wb_addr_o  out  ADDR_WIDTH  Wishbone address
wb_data_o  out  DATA_WIDTH  Wishbone write data
wb_sel_o  out  DATA_WIDTH/8  Wishbone byte select
wb_data_i  in  DATA_WIDTH  Wishbone read data
wb_ack_i  in  1  Wishbone acknowledge
wb_err_i  in  1  Wishbone error

Behaviour:
- All outputs registered. Reset values:
  - req_ready_o, rsp_valid_o, wb_cyc_o, wb_stb_o, wb_we_o, rsp_err_o: 0
  - wb_addr_o, wb_data_o, wb_sel_o, rsp_rdata_o: 0
  - round-robin pointer: 0
  - timeout counter: 0
  - FSM: IDLE
- FSM states:
  - IDLE
    - If any req_valid_i: select winner per ARB_MODE.
    - Pulse req_ready_o[winner] for one cycle.
    - Latch we/addr/wdata/be.
    - Go to BUS.
  - BUS
    - wb_cyc_o = wb_stb_o = 1 with the latched fields; timeout counter increments each cycle.
    - On wb_ack_i: capture wb_data_i (reads; writes return 0), go to RESP with err = 0.
    - On wb_err_i: go to RESP with err = 1. If ack and err arrive together, err wins.
    - On counter reaching TIMEOUT_CYCLES-1: go to RESP with err = 1.
    - cyc/stb drop in the cycle after ack/err/timeout is seen.
  - RESP
    - rsp_valid_o[winner] = 1 for exactly one cycle with rsp_rdata_o/rsp_err_o.
    - Counter cleared; go to IDLE.
- Latency:
  - Request sampled at cycle T.
  - req_ready_o high at T+1; cyc/stb high from T+1.
  - Zero-wait slave acks at T+1 → rsp_valid_o at T+3.
  - Back-to-back: new arbitration in IDLE on the cycle after RESP; minimum 3 cycles per transaction.
- Handshake: a port holds req_valid_i and its fields stable until req_ready_o. Ports keep at most one transaction outstanding; a port must not reassert req_valid_i before its rsp_valid_o. req_valid_i dropped before ready: no transaction, no error.
- Arbitration:
  - ARB_MODE 0: lowest asserted index.
  - ARB_MODE 1: first asserted index at or above the pointer, wrapping modulo NUM_PORTS. Pointer ← winner+1 (wraps to 0 past NUM_PORTS-1) on each grant.
  - NUM_PORTS = 1: arbitration logic degenerates; the port is always granted.
- Timeout: TIMEOUT_CYCLES = 0 means wait forever. Counter width is $clog2(TIMEOUT_CYCLES+1).
- Reset mid-transaction: rst in BUS drops cyc/stb next cycle; no rsp_valid_o is emitted for the aborted request.
- wb_ack_i/wb_err_i outside BUS are ignored.

Decomposition:
- Package core_bus_pkg:
  - bridge_state_e enum (IDLE, BUS, RESP)
  - ARB_FIXED / ARB_RR constants
  - helper function for SEL width (DATA_WIDTH/8)
- One sub-module, rr_arbiter:
  - parameters NUM_PORTS and ARB_MODE
  - inputs: req vector, grant-enable
  - outputs: one-hot grant + index
  - owns the round-robin pointer

Test Plan:
- NUM_PORTS=2, ARB_MODE=0; port1 read addr 0x100, slave acks with 0xDEADBEEF one cycle after stb → rsp_valid_o=2'b10, rsp_rdata_o=0xDEADBEEF, rsp_err_o=0, rsp_valid_o 3 cycles after request.
- Port0 write addr 0x200, data 0x12345678, be=4'b0011 → wb_we_o=1, wb_sel_o=4'b0011, wb_data_o=0x12345678 while cyc high; rsp_valid_o=2'b01, rsp_err_o=0.
- ARB_MODE=1, both ports request continuously → grants alternate 0,1,0,1 over four transactions; ARB_MODE=0 same stimulus → port0 wins every time it requests.
- TIMEOUT_CYCLES=16, slave never acks → cyc drops after 16 cycles of cyc, rsp_err_o=1 with rsp_valid_o; next request proceeds normally.
- Slave asserts wb_ack_i and wb_err_i in the same cycle → rsp_err_o=1; stray wb_ack_i in IDLE → no response generated.
- rst asserted while cyc high → wb_cyc_o=0 next cycle, no rsp_valid_o, round-robin pointer back to 0.
